fsync_nbr_node: RTL and testbench

- Responder (slave) end of the fractal_sync neighbor channel.
- Sits between two adjacent tiles, side A and side B, on the hn or vn link; each tile's OBI fsync controller drives one side.
- Collects one sync request per side, compares aggregate and id fields, then answers both sides with a one-cycle wake or a one-cycle error.
- One instance per horizontal or vertical neighbor pair in the mesh.

---
 rtl/magia_tile_pkg.sv | 26 ++
 rtl/fsync_nbr_node.sv | 121 ++++++++++++
 tb/tb_fsync_nbr_node.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/magia_tile_pkg.sv
// Shared tile types for the fractal_sync neighbor node: state encoding,
// default field widths and the latched request record.
package magia_tile_pkg;

    localparam int unsigned FSYNC_NBR_AGGR_W = 2;
    localparam int unsigned FSYNC_NBR_ID_W   = 4;

    typedef enum logic [2:0] {
        FSYNC_NBR_IDLE   = 3'd0,
        FSYNC_NBR_WAIT_A = 3'd1,
        FSYNC_NBR_WAIT_B = 3'd2,
        FSYNC_NBR_WAKE   = 3'd3,
        FSYNC_NBR_ERR    = 3'd4
    } fsync_nbr_state_e;

    typedef struct packed {
        logic [FSYNC_NBR_AGGR_W-1:0] aggr;
        logic [FSYNC_NBR_ID_W-1:0]   id;
    } fsync_nbr_req_t;

    // Two requests belong to the same barrier only if every bit of aggr and id agrees.
    function automatic logic fsync_nbr_match(input fsync_nbr_req_t x, input fsync_nbr_req_t y);
        return (x.aggr == y.aggr) && (x.id == y.id);
    endfunction

endpackage

// File: rtl/fsync_nbr_node.sv
// Responder end of a fractal_sync neighbor link. Pairs one sync from side A
// with one from side B, then pulses wake (match) or error (mismatch,
// duplicate, timeout) to both sides for one cycle.
// Optional: define FSYNC_NBR_TIMEOUT_EN to abort a pending request after
// TIMEOUT_CYCLES cycles in a WAIT state.
module fsync_nbr_node
    import magia_tile_pkg::*;
#(
    parameter int unsigned NBR_AGGR_W     = FSYNC_NBR_AGGR_W,
    parameter int unsigned NBR_ID_W       = FSYNC_NBR_ID_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_reg_g,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  a_sync_i,
    input  logic [NBR_AGGR_W-1:0] a_aggr_i,
    input  logic [NBR_ID_W-1:0]   a_id_i,
    output logic                  a_wake_o,
    output logic                  a_error_o,
    input  logic                  b_sync_i,
    input  logic [NBR_AGGR_W-1:0] b_aggr_i,
    input  logic [NBR_ID_W-1:0]   b_id_i,
    output logic                  b_wake_o,
    output logic                  b_error_o,
    output logic                  busy_o
);

    localparam logic [2:0] ST_IDLE   = FSYNC_NBR_IDLE;
    localparam logic [2:0] ST_WAIT_A = FSYNC_NBR_WAIT_A;
    localparam logic [2:0] ST_WAIT_B = FSYNC_NBR_WAIT_B;
    localparam logic [2:0] ST_WAKE   = FSYNC_NBR_WAKE;
    localparam logic [2:0] ST_ERR    = FSYNC_NBR_ERR;

    logic [2:0]     state_q, state_d;
    fsync_nbr_req_t a_q, a_d, b_q, b_d;
    fsync_nbr_req_t a_live, b_live;
    logic           waiting;
    logic           timeout;

    assign a_live.aggr = a_aggr_i;
    assign a_live.id   = a_id_i;
    assign b_live.aggr = b_aggr_i;
    assign b_live.id   = b_id_i;

    assign waiting = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_B);

`ifdef FSYNC_NBR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Cycles spent pending; restarts from 0 on every entry into a WAIT state.
    always_ff @(posedge clk_reg_g or negedge rst_ni) begin
        if (!rst_ni)      cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else if (waiting) cnt_q <= cnt_q + 1'b1;
        else              cnt_q <= '0;
    end

    assign timeout = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Next-state and latch update; WAKE/ERR reuse the IDLE rules so a new
    // barrier can start in the same cycle the previous one completes.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            ST_WAIT_B: begin
                if (a_sync_i)      state_d = ST_ERR;
                else if (b_sync_i) state_d = fsync_nbr_match(b_live, a_q) ? ST_WAKE : ST_ERR;
                else if (timeout)  state_d = ST_ERR;
            end
            ST_WAIT_A: begin
                if (b_sync_i)      state_d = ST_ERR;
                else if (a_sync_i) state_d = fsync_nbr_match(a_live, b_q) ? ST_WAKE : ST_ERR;
                else if (timeout)  state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
                if (a_sync_i && b_sync_i) begin
                    state_d = fsync_nbr_match(a_live, b_live) ? ST_WAKE : ST_ERR;
                end else if (a_sync_i) begin
                    a_d     = a_live;
                    state_d = ST_WAIT_B;
                end else if (b_sync_i) begin
                    b_d     = b_live;
                    state_d = ST_WAIT_A;
                end
            end
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
            a_d     = '0;
            b_d     = '0;
        end
    end

    // State and request latches.
    always_ff @(posedge clk_reg_g or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a_wake_o  = (state_q == ST_WAKE);
    assign b_wake_o  = (state_q == ST_WAKE);
    assign a_error_o = (state_q == ST_ERR);
    assign b_error_o = (state_q == ST_ERR);
    assign busy_o    = waiting;

endmodule

// File: tb/tb_fsync_nbr_node.sv
// Self-checking bench for fsync_nbr_node: directed plan scenarios plus a
// randomized run against a pending-request reference model.
module tb_fsync_nbr_node;
    import magia_tile_pkg::*;

    localparam int unsigned AW = FSYNC_NBR_AGGR_W;
    localparam int unsigned IW = FSYNC_NBR_ID_W;
    localparam int unsigned TO = 8;
`ifdef FSYNC_NBR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_reg_g = 1'b0;
    logic          rst_ni    = 1'b0;
    logic          clear_i   = 1'b0;
    logic          a_sync_i  = 1'b0;
    logic [AW-1:0] a_aggr_i  = '0;
    logic [IW-1:0] a_id_i    = '0;
    logic          b_sync_i  = 1'b0;
    logic [AW-1:0] b_aggr_i  = '0;
    logic [IW-1:0] b_id_i    = '0;
    logic          a_wake_o, a_error_o, b_wake_o, b_error_o, busy_o;

    int nchk = 0;
    int nerr = 0;

    // Reference model: which side is pending (0 none, 1 A, 2 B), its
    // request, cycles pending, and the outcome shown this cycle.
    int            m_pend = 0;
    logic [AW-1:0] m_aggr = '0;
    logic [IW-1:0] m_id   = '0;
    int            m_wait = 0;
    int            m_out  = 0;  // 0 none, 1 wake, 2 error

    fsync_nbr_node #(
        .NBR_AGGR_W    (AW),
        .NBR_ID_W      (IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_reg_g(clk_reg_g),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .a_sync_i (a_sync_i),
        .a_aggr_i (a_aggr_i),
        .a_id_i   (a_id_i),
        .a_wake_o (a_wake_o),
        .a_error_o(a_error_o),
        .b_sync_i (b_sync_i),
        .b_aggr_i (b_aggr_i),
        .b_id_i   (b_id_i),
        .b_wake_o (b_wake_o),
        .b_error_o(b_error_o),
        .busy_o   (busy_o)
    );

    always #5 clk_reg_g = ~clk_reg_g;

    function automatic logic [4:0] obs();
        return {a_wake_o, b_wake_o, a_error_o, b_error_o, busy_o};
    endfunction

    function automatic logic [4:0] mexp();
        logic w, e;
        w = (m_out == 1);
        e = (m_out == 2);
        return {w, w, e, e, (m_pend != 0)};
    endfunction

    // Advance the model by one cycle from the inputs it is about to see.
    task automatic model_step(input bit as, input logic [AW-1:0] aa, input logic [IW-1:0] ai,
                              input bit bs, input logic [AW-1:0] ba, input logic [IW-1:0] bi,
                              input bit clr);
        if (clr) begin
            m_pend = 0; m_out = 0;
        end else if (m_pend == 0) begin
            m_out = 0;
            if (as && bs) m_out = (aa == ba && ai == bi) ? 1 : 2;
            else if (as) begin m_pend = 1; m_aggr = aa; m_id = ai; m_wait = 0; end
            else if (bs) begin m_pend = 2; m_aggr = ba; m_id = bi; m_wait = 0; end
        end else begin
            bit own, other;
            logic [AW-1:0] oa;
            logic [IW-1:0] oi;
            own   = (m_pend == 1) ? as : bs;
            other = (m_pend == 1) ? bs : as;
            oa    = (m_pend == 1) ? ba : aa;
            oi    = (m_pend == 1) ? bi : ai;
            if (own) begin
                m_out = 2; m_pend = 0;
            end else if (other) begin
                m_out = (oa == m_aggr && oi == m_id) ? 1 : 2; m_pend = 0;
            end else if (TO_EN && m_wait == TO - 1) begin
                m_out = 2; m_pend = 0;
            end else begin
                m_out = 0; m_wait++;
            end
        end
    endtask

    // Apply one cycle of inputs; returns 1 ns after the sampling edge.
    task automatic step(input bit as, input logic [AW-1:0] aa, input logic [IW-1:0] ai,
                        input bit bs, input logic [AW-1:0] ba, input logic [IW-1:0] bi,
                        input bit clr);
        a_sync_i = as; a_aggr_i = aa; a_id_i = ai;
        b_sync_i = bs; b_aggr_i = ba; b_id_i = bi;
        clear_i  = clr;
        model_step(as, aa, ai, bs, ba, bi, clr);
        @(posedge clk_reg_g);
        #1;
        a_sync_i = 1'b0; b_sync_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic idle();
        step(0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic test_reset();
        #2;
        nchk++;
        if (obs() !== 5'b0) begin nerr++; $display("FAIL reset_outputs got=%b want=00000", obs()); end
        @(negedge clk_reg_g);
        rst_ni = 1'b1;
        @(posedge clk_reg_g); #1;
        nchk++;
        if (obs() !== 5'b0) begin nerr++; $display("FAIL post_reset_idle got=%b want=00000", obs()); end
    endtask

    task automatic test_seq_wake();
        step(1, 2'd1, 4'd3, 0, '0, '0, 0);                 // cycle 0
        for (int c = 1; c <= 5; c++) begin
            nchk++;
            if (obs() !== 5'b00001 || obs() !== mexp())
                begin nerr++; $display("FAIL seq_busy c=%0d got=%b want=00001", c, obs()); end
            if (c < 5) idle();
            else step(0, '0, '0, 1, 2'd1, 4'd3, 0);         // B at cycle 5
        end
        nchk++;
        if (obs() !== 5'b11000) begin nerr++; $display("FAIL seq_wake got=%b want=11000", obs()); end
        idle();
        nchk++;
        if (obs() !== 5'b00000) begin nerr++; $display("FAIL seq_after got=%b want=00000", obs()); end
    endtask

    task automatic test_simul();
        step(1, 2'd1, 4'd2, 1, 2'd1, 4'd2, 0);
        nchk++;
        if (obs() !== 5'b11000) begin nerr++; $display("FAIL simul_wake got=%b want=11000", obs()); end
        idle();
        nchk++;
        if (obs() !== 5'b00000) begin nerr++; $display("FAIL simul_after got=%b want=00000", obs()); end
    endtask

    task automatic test_mismatch();
        step(1, 2'd0, 4'd1, 0, '0, '0, 0);
        step(0, '0, '0, 1, 2'd0, 4'd2, 0);
        nchk++;
        if (obs() !== 5'b00110) begin nerr++; $display("FAIL mismatch_err got=%b want=00110", obs()); end
        // aggr differs only in its top bit
        step(0, '0, '0, 1, 2'b10, 4'd5, 0);
        step(1, 2'b00, 4'd5, 0, '0, '0, 0);
        nchk++;
        if (obs() !== 5'b00110) begin nerr++; $display("FAIL mismatch_aggr got=%b want=00110", obs()); end
        idle();
    endtask

    task automatic test_duplicate();
        step(1, 2'd1, 4'd4, 0, '0, '0, 0);                 // cycle 0
        idle(); idle();
        step(1, 2'd1, 4'd4, 0, '0, '0, 0);                 // cycle 3
        nchk++;
        if (obs() !== 5'b00110) begin nerr++; $display("FAIL dup_err got=%b want=00110", obs()); end
        step(0, '0, '0, 1, 2'd2, 4'd6, 0);
        nchk++;
        if (obs() !== 5'b00001) begin nerr++; $display("FAIL dup_fresh_wait got=%b want=00001", obs()); end
        step(1, 2'd2, 4'd6, 0, '0, '0, 0);
        nchk++;
        if (obs() !== 5'b11000) begin nerr++; $display("FAIL dup_fresh_wake got=%b want=11000", obs()); end
        idle();
    endtask

    task automatic test_back_to_back();
        step(1, 2'd3, 4'd9, 1, 2'd3, 4'd9, 0);
        step(1, 2'd0, 4'd0, 1, 2'd0, 4'd0, 0);             // syncs during WAKE cycle
        nchk++;
        if (obs() !== 5'b11000) begin nerr++; $display("FAIL b2b_wake got=%b want=11000", obs()); end
        idle();
        nchk++;
        if (obs() !== 5'b00000) begin nerr++; $display("FAIL b2b_after got=%b want=00000", obs()); end
    endtask

    task automatic test_clear();
        step(1, 2'd1, 4'd7, 0, '0, '0, 0);
        step(0, '0, '0, 0, '0, '0, 1);
        nchk++;
        if (obs() !== 5'b00000) begin nerr++; $display("FAIL clear_idle got=%b want=00000", obs()); end
        step(0, '0, '0, 1, 2'd1, 4'd7, 0);                 // dropped A must not pair
        nchk++;
        if (obs() !== 5'b00001) begin nerr++; $display("FAIL clear_dropped got=%b want=00001", obs()); end
        step(1, 2'd1, 4'd7, 1, 2'd1, 4'd7, 1);             // clear beats syncs
        nchk++;
        if (obs() !== 5'b00000) begin nerr++; $display("FAIL clear_priority got=%b want=00000", obs()); end
    endtask

    task automatic test_timeout();
        step(1, 2'd1, 4'd1, 0, '0, '0, 0);                 // cycle 0
`ifdef FSYNC_NBR_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            nchk++;
            if (obs() !== 5'b00001) begin nerr++; $display("FAIL to_busy c=%0d got=%b want=00001", c, obs()); end
            idle();
        end
        nchk++;
        if (obs() !== 5'b00110) begin nerr++; $display("FAIL to_err got=%b want=00110", obs()); end
        idle();
`else
        for (int c = 1; c < 100; c++) idle();
        nchk++;
        if (obs() !== 5'b00001) begin nerr++; $display("FAIL to_hold got=%b want=00001", obs()); end
        step(0, '0, '0, 0, '0, '0, 1);
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 1)), IW'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 1)), IW'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
            nchk++;
            if (obs() !== mexp()) begin nerr++; $display("FAIL random i=%0d got=%b want=%b", i, obs(), mexp()); end
        end
    endtask

    initial begin
        test_reset();
        test_seq_wake();
        test_simul();
        test_mismatch();
        test_duplicate();
        test_back_to_back();
        test_clear();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
